// File: rtl/bht_controller.sv
// Branch history table controller: 2-bit saturating counters with an init sweep,
// single-cycle fetch lookups and a queued read-modify-write update path.
module bht_controller #(
  parameter int ENTRIES  = 64,
  parameter int IDX_W    = $clog2(ENTRIES),
  parameter int PC_W     = 32,
  parameter int UQ_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            lookup_valid,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            lookup_ready,
  output logic            pred_valid,
  output logic            pred_taken,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  output logic            upd_ready,
  output logic            init_busy
);

  localparam int QP_W = $clog2(UQ_DEPTH);
  localparam int QC_W = QP_W + 1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] init_ptr_q, init_ptr_d;

  logic [1:0]       ctr [ENTRIES];
  logic [IDX_W-1:0] q_idx   [UQ_DEPTH];
  logic             q_taken [UQ_DEPTH];
  logic [QP_W-1:0]  head_q, tail_q;
  logic [QC_W-1:0]  count_q;

  logic             run, full, empty, enq, deq, lookup_fire;
  logic [IDX_W-1:0] lookup_idx, upd_idx, drain_idx;
  logic [1:0]       drain_old, drain_new;
  logic             pred_bit;
  logic             pred_valid_q, pred_taken_q;

  // Upper and byte-offset PC bits never reach the index; aliasing is intended.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0],
                            upd_pc[PC_W-1:IDX_W+2], upd_pc[1:0]};

  assign lookup_idx = lookup_pc[IDX_W+1:2];
  assign upd_idx    = upd_pc[IDX_W+1:2];

  assign run          = (state_q == ST_RUN);
  assign init_busy    = (state_q == ST_INIT);
  assign full         = (count_q == QC_W'(UQ_DEPTH));
  assign empty        = (count_q == '0);
  assign lookup_ready = run && !flush;
  assign upd_ready    = !full && !flush;
  assign lookup_fire  = lookup_valid && lookup_ready;
  assign enq          = upd_valid && upd_ready;
  assign deq          = run && !empty && !flush;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    if (flush) begin
      state_d    = ST_INIT;
      init_ptr_d = '0;
    end else if (state_q == ST_INIT) begin
      if (init_ptr_q == IDX_W'(ENTRIES - 1)) begin
        state_d    = ST_RUN;
        init_ptr_d = '0;
      end else begin
        init_ptr_d = init_ptr_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_INIT;
      init_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
    end
  end

  // Drain read-modify-write: saturating increment on taken, decrement otherwise.
  assign drain_idx = q_idx[head_q];
  always_comb begin
    drain_old = ctr[drain_idx];
    drain_new = drain_old;
    if (q_taken[head_q]) begin
      if (drain_old != 2'b11) drain_new = drain_old + 2'b01;
    end else begin
      if (drain_old != 2'b00) drain_new = drain_old - 2'b01;
    end
  end

  // NOTE: storage arrays carry no reset; the init sweep defines the counters
  // and queue slots are only read after being written.
  always_ff @(posedge clk) begin
    if (init_busy) begin
      ctr[init_ptr_q] <= 2'b01;
    end else if (deq) begin
      ctr[drain_idx] <= drain_new;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_idx[tail_q]   <= upd_idx;
      q_taken[tail_q] <= upd_taken;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) tail_q <= tail_q + 1'b1;
      if (deq) head_q <= head_q + 1'b1;
      case ({enq, deq})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Write-first bypass: a same-cycle drain to the looked-up index wins.
  assign pred_bit = (deq && (drain_idx == lookup_idx)) ? drain_new[1]
                                                       : ctr[lookup_idx][1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
    end else begin
      pred_valid_q <= lookup_fire;
      if (lookup_fire) pred_taken_q <= pred_bit;
    end
  end

  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_taken_q;

endmodule

// File: tb/tb_bht_controller.sv
// Self-checking bench for bht_controller: directed scenarios plus random traffic
// compared against a queue/array model of the table's rules.
module tb_bht_controller;

  localparam int ENTRIES  = 64;
  localparam int PC_W     = 32;
  localparam int UQ_DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic            lookup_valid;
  logic [PC_W-1:0] lookup_pc;
  logic            lookup_ready;
  logic            pred_valid;
  logic            pred_taken;
  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic            upd_taken;
  logic            upd_ready;
  logic            init_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bht_controller #(
    .ENTRIES (ENTRIES),
    .PC_W    (PC_W),
    .UQ_DEPTH(UQ_DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .lookup_valid(lookup_valid),
    .lookup_pc   (lookup_pc),
    .lookup_ready(lookup_ready),
    .pred_valid  (pred_valid),
    .pred_taken  (pred_taken),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_ready   (upd_ready),
    .init_busy   (init_busy)
  );

  // Reference model: counters as integers, pending updates as a queue,
  // initialization as a count of sweep cycles still owed.
  typedef struct {
    int idx;
    bit taken;
  } upd_t;

  int   m_ctr [ENTRIES];
  upd_t m_q [$];
  bit   m_busy;
  int   m_sweep;
  bit   m_pv;
  bit   m_pt;
  logic obs_upd_ready;

  function automatic int idx_of(input logic [PC_W-1:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  task automatic model_reset();
    m_busy  = 1'b1;
    m_sweep = 0;
    m_q.delete();
    m_pv    = 1'b0;
    m_pt    = 1'b0;
    foreach (m_ctr[i]) m_ctr[i] = -1;
  endtask

  // One clock cycle: drive inputs after the falling edge, check combinational
  // outputs, advance the model at the rising edge, check registered outputs.
  task automatic step(input bit fl, input bit lv, input logic [PC_W-1:0] lpc,
                      input bit uv, input logic [PC_W-1:0] upc, input bit ut);
    bit   can_enq;
    bit   exp_lr;
    bit   exp_ur;
    upd_t u;
    flush        = fl;
    lookup_valid = lv;
    lookup_pc    = lpc;
    upd_valid    = uv;
    upd_pc       = upc;
    upd_taken    = ut;
    #1;
    exp_lr = !m_busy && !fl;
    exp_ur = (m_q.size() < UQ_DEPTH) && !fl;
    checks += 3;
    if (init_busy !== m_busy) begin
      errors++;
      $display("FAIL init_busy @%0t: got %b expected %b", $time, init_busy, m_busy);
    end
    if (lookup_ready !== exp_lr) begin
      errors++;
      $display("FAIL lookup_ready @%0t: got %b expected %b", $time, lookup_ready, exp_lr);
    end
    if (upd_ready !== exp_ur) begin
      errors++;
      $display("FAIL upd_ready @%0t: got %b expected %b", $time, upd_ready, exp_ur);
    end
    obs_upd_ready = upd_ready;
    @(posedge clk);
    if (fl) begin
      m_q.delete();
      m_busy  = 1'b1;
      m_sweep = 0;
      m_pv    = 1'b0;
    end else begin
      can_enq = (m_q.size() < UQ_DEPTH);
      if (m_busy) begin
        m_pv = 1'b0;
        m_sweep++;
        if (m_sweep == ENTRIES) begin
          m_busy = 1'b0;
          foreach (m_ctr[i]) m_ctr[i] = 1;
        end
      end else begin
        if (m_q.size() > 0) begin
          u = m_q.pop_front();
          m_ctr[u.idx] = u.taken ? ((m_ctr[u.idx] < 3) ? m_ctr[u.idx] + 1 : 3)
                                 : ((m_ctr[u.idx] > 0) ? m_ctr[u.idx] - 1 : 0);
        end
        m_pv = lv;
        if (lv) m_pt = (m_ctr[idx_of(lpc)] >= 2);
      end
      if (uv && can_enq) m_q.push_back('{idx: idx_of(upc), taken: ut});
    end
    #1;
    checks += 2;
    if (pred_valid !== m_pv) begin
      errors++;
      $display("FAIL pred_valid @%0t: got %b expected %b", $time, pred_valid, m_pv);
    end
    if (pred_taken !== m_pt) begin
      errors++;
      $display("FAIL pred_taken @%0t: got %b expected %b", $time, pred_taken, m_pt);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic lookup(input logic [PC_W-1:0] pc);
    step(1'b0, 1'b1, pc, 1'b0, '0, 1'b0);
  endtask

  task automatic update(input logic [PC_W-1:0] pc, input bit taken);
    step(1'b0, 1'b0, '0, 1'b1, pc, taken);
  endtask

  // Idles until the sweep ends, returning the number of busy cycles seen.
  task automatic wait_sweep(output int n);
    n = 0;
    while (init_busy === 1'b1 && n < 200) begin
      idle();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    reset        = 1'b0;
    flush        = 1'b0;
    lookup_valid = 1'b0;
    lookup_pc    = '0;
    upd_valid    = 1'b0;
    upd_pc       = '0;
    upd_taken    = 1'b0;
    model_reset();
    #3;
    checks += 5;
    if (pred_valid !== 1'b0) begin errors++; $display("FAIL reset_pred_valid: got %b expected 0", pred_valid); end
    if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken: got %b expected 0", pred_taken); end
    if (init_busy !== 1'b1) begin errors++; $display("FAIL reset_init_busy: got %b expected 1", init_busy); end
    if (lookup_ready !== 1'b0) begin errors++; $display("FAIL reset_lookup_ready: got %b expected 0", lookup_ready); end
    if (upd_ready !== 1'b1) begin errors++; $display("FAIL reset_upd_ready: got %b expected 1", upd_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    wait_sweep(n);
    checks++;
    if (n != ENTRIES) begin errors++; $display("FAIL reset_sweep_len: got %0d expected %0d", n, ENTRIES); end
    lookup(32'h44);
    checks += 2;
    if (pred_valid !== 1'b1) begin errors++; $display("FAIL first_lookup_valid: got %b expected 1", pred_valid); end
    if (pred_taken !== 1'b0) begin errors++; $display("FAIL first_lookup_taken: got %b expected 0", pred_taken); end
  endtask

  task automatic test_counting();
    repeat (3) update(32'h44, 1'b1);
    repeat (2) idle();
    lookup(32'h44);
    checks++;
    if (pred_taken !== 1'b1) begin errors++; $display("FAIL count_up_taken: got %b expected 1", pred_taken); end
    repeat (2) update(32'h44, 1'b0);
    repeat (2) idle();
    lookup(32'h44);
    checks++;
    if (pred_taken !== 1'b0) begin errors++; $display("FAIL count_down_taken: got %b expected 0", pred_taken); end
  endtask

  task automatic test_bypass();
    update(32'h44, 1'b1);
    lookup(32'h44);
    checks++;
    if (pred_taken !== 1'b1) begin errors++; $display("FAIL bypass_same_idx: got %b expected 1", pred_taken); end
    update(32'h44, 1'b1);
    lookup(32'h48);
    checks++;
    if (pred_taken !== 1'b0) begin errors++; $display("FAIL bypass_other_idx: got %b expected 0", pred_taken); end
  endtask

  task automatic test_queue_full_init();
    int n;
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      update(32'h100 + 32'(i * 4), 1'b1);
      checks++;
      if (obs_upd_ready !== (i < UQ_DEPTH)) begin
        errors++;
        $display("FAIL init_enq_ready[%0d]: got %b expected %b", i, obs_upd_ready, (i < UQ_DEPTH));
      end
    end
    wait_sweep(n);
    checks++;
    if (n != ENTRIES - 5) begin errors++; $display("FAIL init_fill_sweep_len: got %0d expected %0d", n, ENTRIES - 5); end
    #1;
    checks++;
    if (upd_ready !== 1'b0) begin errors++; $display("FAIL full_before_pop: got %b expected 0", upd_ready); end
    idle();
    checks++;
    if (upd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_pop: got %b expected 1", upd_ready); end
    repeat (3) idle();
    for (int i = 0; i < 5; i++) begin
      lookup(32'h100 + 32'(i * 4));
      checks++;
      if (pred_taken !== (i < UQ_DEPTH)) begin
        errors++;
        $display("FAIL drained_ctr[%0d]: got %b expected %b", i, pred_taken, (i < UQ_DEPTH));
      end
    end
  endtask

  task automatic test_flush();
    int n;
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      if (i < 3) update(32'h44, 1'b1);
      else idle();
    end
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    checks++;
    if (pred_valid !== 1'b0) begin errors++; $display("FAIL flush_pred_valid: got %b expected 0", pred_valid); end
    wait_sweep(n);
    checks++;
    if (n != ENTRIES) begin errors++; $display("FAIL restart_sweep_len: got %0d expected %0d", n, ENTRIES); end
    repeat (3) idle();
    lookup(32'h44);
    checks++;
    if (pred_taken !== 1'b0) begin errors++; $display("FAIL flush_dropped_updates: got %b expected 0", pred_taken); end
    for (int i = 0; i < 4; i++) lookup($urandom);
  endtask

  task automatic test_random();
    bit fl, lv, uv, ut;
    logic [PC_W-1:0] lpc, upc;
    for (int i = 0; i < 800; i++) begin
      fl  = ($urandom_range(0, 99) == 0);
      lv  = $urandom_range(0, 1) == 1;
      uv  = $urandom_range(0, 1) == 1;
      ut  = $urandom_range(0, 1) == 1;
      lpc = ($urandom << 8) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      upc = ($urandom << 8) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      step(fl, lv, lpc, uv, upc, ut);
    end
  endtask

  task automatic test_async_reset();
    int n;
    wait_sweep(n);
    step(1'b0, 1'b1, 32'h44, 1'b1, 32'h44, 1'b1);
    step(1'b0, 1'b1, 32'h44, 1'b1, 32'h44, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    checks += 5;
    if (pred_valid !== 1'b0) begin errors++; $display("FAIL async_pred_valid: got %b expected 0", pred_valid); end
    if (pred_taken !== 1'b0) begin errors++; $display("FAIL async_pred_taken: got %b expected 0", pred_taken); end
    if (init_busy !== 1'b1) begin errors++; $display("FAIL async_init_busy: got %b expected 1", init_busy); end
    if (lookup_ready !== 1'b0) begin errors++; $display("FAIL async_lookup_ready: got %b expected 0", lookup_ready); end
    if (upd_ready !== 1'b1) begin errors++; $display("FAIL async_upd_ready: got %b expected 1", upd_ready); end
    model_reset();
    upd_valid    = 1'b0;
    lookup_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    wait_sweep(n);
    checks++;
    if (n != ENTRIES) begin errors++; $display("FAIL async_sweep_len: got %0d expected %0d", n, ENTRIES); end
    repeat (3) idle();
    lookup(32'h44);
    checks++;
    if (pred_taken !== 1'b0) begin errors++; $display("FAIL async_queue_dropped: got %b expected 0", pred_taken); end
  endtask

  initial begin
    test_reset();
    test_counting();
    test_bypass();
    test_queue_full_init();
    test_flush();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
